iterative_mdu: RTL and testbench

//   Sequential multiply/divide unit for the CPU datapath. It adds MUL/MULU/DIV/DIVU, which the

---
 rtl/iterative_mdu.sv | 124 ++++++++++++
 tb/tb_iterative_mdu.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/iterative_mdu.sv
// iterative_mdu: radix-2 iterative multiply/divide unit writing results to HI/LO
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start, op          request (sampled while idle) and opcode: 00 MUL, 01 MULU, 10 DIV, 11 DIVU
//   operand1/operand2  multiplicand/dividend and multiplier/divisor
//   busy, done         unit occupied (RUN or FIX), one-cycle result strobe
//   hi, lo, err        product high/low or remainder/quotient, divide error flag
// Configuration: define MDU_DIV_EN to build the restoring divider; without it every
//   divide op returns hi=0, lo=0, err=1 after a short two-cycle pass through FIX.
module iterative_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_div;
    logic               r_neg;
    logic               r_err;
    logic               r_skip;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_p;
    logic               w_sa, w_sb, w_short;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_init_lo;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next, w_step, w_prod;
    logic [WIDTH-1:0]   w_div_hi, w_div_lo;
    assign w_sa    = ~op[0] & operand1[WIDTH-1];
    assign w_sb    = ~op[0] & operand2[WIDTH-1];
    assign w_mag_a = w_sa ? -operand1 : operand1;
    assign w_mag_b = w_sb ? -operand2 : operand2;
    // Shift-add: r_b holds the multiplicand, the low half of r_p the remaining multiplier bits
    assign w_sum      = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_sum, r_p[WIDTH-1:1]};
    assign w_prod     = r_neg ? -r_p : r_p;
    assign busy       = (r_state != S_IDLE);
`ifdef MDU_DIV_EN
    logic               r_neg_r;
    logic [WIDTH:0]     w_sh, w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    // Restoring step: r_p = {partial remainder, dividend bits shifting into quotient}
    assign w_sh       = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_diff     = w_sh - {1'b0, r_b};
    assign w_div_next = {w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0], r_p[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_step     = r_div ? w_div_next : w_mul_next;
    assign w_short    = op[1] & (operand2 == '0);
    // Divide by zero keeps the raw dividend in r_p so it can be returned in hi
    assign w_init_lo  = op[1] ? (w_short ? operand1 : w_mag_a) : w_mag_b;
    always_comb begin
        w_div_hi = r_err ? r_p[WIDTH-1:0] : (r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH]);
        w_div_lo = r_err ? '1 : (r_neg ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0]);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) r_neg_r <= 1'b0;
        else if (r_state == S_IDLE && start) r_neg_r <= w_sa;
`else
    assign w_step    = w_mul_next;
    assign w_short   = op[1];
    assign w_init_lo = w_mag_b;
    always_comb begin
        w_div_hi = '0;
        w_div_lo = '0;
    end
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
            r_skip  <= 1'b0;
            r_b     <= '0;
            r_p     <= '0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_div   <= op[1];
                    r_neg   <= w_sa ^ w_sb;
                    r_err   <= w_short;
                    r_skip  <= w_short;
                    r_b     <= op[1] ? w_mag_b : w_mag_a;
                    r_p     <= {{WIDTH{1'b0}}, w_init_lo};
                    r_cnt   <= '0;
                    r_state <= w_short ? S_FIX : S_RUN;
                end
                S_RUN: begin
                    r_p     <= w_step;
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= (r_cnt == CNT_W'(WIDTH - 1)) ? S_FIX : S_RUN;
                end
                S_FIX: begin
                    // Short (no-iteration) ops spend one settle cycle here so done lands two cycles after accept
                    if (r_skip) r_skip <= 1'b0;
                    else begin
                        hi      <= r_div ? w_div_hi : w_prod[2*WIDTH-1:WIDTH];
                        lo      <= r_div ? w_div_lo : w_prod[WIDTH-1:0];
                        err     <= r_err;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_mdu.sv
// tb_iterative_mdu: directed self-checking bench for iterative_mdu at WIDTH=32
module tb_iterative_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic        busy, done, err;
    logic [31:0] hi, lo;
    int checks = 0;
    int errors = 0;

    iterative_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand1(operand1), .operand2(operand2),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .err(err)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        start = 1'b0; operand1 = 32'hDEADBEEF; operand2 = 32'h12345678; op = 2'b10;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_res(input string name, input int lat, input int exp_lat,
                             input logic [31:0] eh, input logic [31:0] el, input logic ee);
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat); end
        checks++;
        if (hi !== eh) begin errors++; $display("FAIL %s hi got %h exp %h", name, hi, eh); end
        checks++;
        if (lo !== el) begin errors++; $display("FAIL %s lo got %h exp %h", name, lo, el); end
        checks++;
        if (err !== ee) begin errors++; $display("FAIL %s err got %b exp %b", name, err, ee); end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset busy/done/err got %b exp 000", {busy, done, err}); end
        checks++;
        if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset hi/lo got %h exp 0", {hi, lo}); end
    endtask

    task automatic test_mul();
        int lat;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        check_res("mulu_max", lat, 33, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op(2'b00, -32'sd7, 32'd3, lat);
        check_res("mul_neg7x3", lat, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op(2'b00, 32'h80000000, 32'h80000000, lat);
        check_res("mul_minxmin", lat, 33, 32'h40000000, 32'h00000000, 1'b0);
        run_op(2'b00, -32'sd5, -32'sd6, lat);
        check_res("mul_neg5xneg6", lat, 33, 32'h0, 32'd30, 1'b0);
        run_op(2'b01, 32'h80000000, 32'd2, lat);
        check_res("mulu_msb", lat, 33, 32'h1, 32'h0, 1'b0);
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        int lat;
        run_op(2'b10, -32'sd7, 32'd2, lat);
        check_res("div_neg7by2", lat, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op(2'b10, 32'd7, -32'sd2, lat);
        check_res("div_7byneg2", lat, 33, 32'h1, 32'hFFFFFFFD, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, lat);
        check_res("divu_100by7", lat, 33, 32'd2, 32'd14, 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
        check_res("div_minbyneg1", lat, 33, 32'h0, 32'h80000000, 1'b0);
        run_op(2'b11, 32'd100, 32'd0, lat);
        check_res("divu_by0", lat, 2, 32'd100, 32'hFFFFFFFF, 1'b1);
        run_op(2'b01, 32'd2, 32'd3, lat);
        check_res("mulu_after_dz", lat, 33, 32'h0, 32'd6, 1'b0);
    endtask
`else
    task automatic test_nodiv();
        int lat;
        run_op(2'b11, 32'd9, 32'd3, lat);
        check_res("nodiv_divu", lat, 2, 32'h0, 32'h0, 1'b1);
        run_op(2'b10, -32'sd7, 32'd2, lat);
        check_res("nodiv_div", lat, 2, 32'h0, 32'h0, 1'b1);
        run_op(2'b01, 32'd2, 32'd3, lat);
        check_res("mulu_after_nodiv", lat, 33, 32'h0, 32'd6, 1'b0);
    endtask
`endif

    task automatic test_ignore_start();
        int bc = 0;
        start = 1'b1; op = 2'b01; operand1 = 32'd5; operand2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        while (busy && bc < 100) begin
            bc++;
            if (bc == 5) begin start = 1'b1; op = 2'b00; operand1 = 32'd7; operand2 = 32'd7; end
            if (bc == 6) start = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (bc !== 33) begin errors++; $display("FAIL ignore busy_cycles got %0d exp 33", bc); end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL ignore done got %b exp 1", done); end
        checks++;
        if (lo !== 32'd25) begin errors++; $display("FAIL ignore lo got %0d exp 25", lo); end
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ignore_not_queued busy/done got %b exp 00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad = 0;
        run_op(2'b01, 32'd2, 32'd2, lat);
        check_res("b2b_first", lat, 33, 32'h0, 32'd4, 1'b0);
        start = 1'b1; op = 2'b01; operand1 = 32'd3; operand2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; operand1 = 32'd0; operand2 = 32'd0;
        lat = 0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b exp 1", busy); end
        while (!done && lat < 100) begin
            if (hi !== 32'h0 || lo !== 32'd4) bad++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL b2b_hold changed_cycles got %0d exp 0", bad); end
        check_res("b2b_second", lat, 33, 32'h0, 32'd9, 1'b0);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
`ifdef MDU_DIV_EN
        start = 1'b1; op = 2'b11; operand1 = 32'd100; operand2 = 32'd7;
`else
        start = 1'b1; op = 2'b01; operand1 = 32'd123; operand2 = 32'd456;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got %b exp 0", busy); end
        checks++;
        if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid hi/lo got %h exp 0", {hi, lo}); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (40) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rst_mid done_pulses got %0d exp 0", seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_nodiv();
`endif
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
